alu_exec_unit: RTL and testbench

//  Execute-stage ALU; consumes the 3-bit ALU control code from the ALU control decoder plus two operands.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mul_iter.sv | 74 +++++++
 rtl/alu_exec_unit.sv | 117 +++++++++++
 tb/tb_alu_exec_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes and FSM state encoding.
package alu_pkg;

  // 3-bit ALU control codes produced by the ALU control decoder
  localparam logic [2:0] ALU_SLL = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_RSV = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  // Execute-unit FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_STEP multiplier bits per cycle,
// producing the low WIDTH bits of the product after K = WIDTH/MUL_STEP cycles.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int K  = WIDTH / MUL_STEP;
  localparam int CW = $clog2(K + 1);

  logic             active_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] term [MUL_STEP];
  logic [WIDTH-1:0] partial;

  // One shifted copy of the multiplicand per multiplier bit retired this cycle
  generate
    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_term
      assign term[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // Sum the partial terms of this iteration
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      partial = partial + term[i];
    end
  end

  // Product including the current iteration, so the last step can be consumed directly
  assign product = acc_reg + partial;
  assign done    = active_reg && (cnt_reg == CW'(K - 1));

  // Operand latch, accumulator and iteration counter
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= mcand;
      mplier_reg <= mplier;
    end else if (active_reg) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << MUL_STEP;
      mplier_reg <= mplier_reg >> MUL_STEP;
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides; single-cycle ops
// complete in one cycle, MUL stalls the pipeline while iterating.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             busy_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic             zero_reg;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;

  assign shamt = data2_i[SHW-1:0];

  // Single-cycle datapath; MUL and the reserved code fall to zero here
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_SLL: alu_res = data1_i << shamt;
      ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB: alu_res = data1_i - data2_i;
      ALU_AND: alu_res = data1_i & data2_i;
      ALU_OR:  alu_res = data1_i | data2_i;
      ALU_SRA: alu_res = $unsigned($signed(data1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // A consumed HOLD behaves like IDLE so results can stream back-to-back
  assign ready_o   = ((state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && ready_i)) && !flush_i;
  assign accept    = valid_i && ready_o;
  assign mul_start = accept && (ALUCtrl_i == ALU_MUL);

  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk     (clk_i),
    .srst    (rst_i),
    .clear   (flush_i),
    .start   (mul_start),
    .mcand   (data1_i),
    .mplier  (data2_i),
    .done    (mul_done),
    .product (mul_res)
  );

  // FSM plus result/handshake registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      zero_reg  <= 1'b1;
    end else if (flush_i) begin
      state_reg <= ST_IDLE;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_MUL: begin
          if (mul_done) begin
            data_reg  <= mul_res;
            zero_reg  <= (mul_res == '0);
            valid_reg <= 1'b1;
            state_reg <= ST_HOLD;
          end
        end
        default: begin
          if (accept) begin
            if (ALUCtrl_i == ALU_MUL) begin
              valid_reg <= 1'b0;
              state_reg <= ST_MUL;
            end else begin
              data_reg  <= alu_res;
              zero_reg  <= (alu_res == '0);
              valid_reg <= 1'b1;
              state_reg <= ST_HOLD;
            end
          end else if ((state_reg == ST_HOLD) && ready_i) begin
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign valid_o = valid_reg;
  assign data_o  = data_reg;
  assign Zero_o  = zero_reg;
  assign busy_o  = (state_reg == ST_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32, MUL_STEP=1).
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        Zero_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one op at the current negedge; it is sampled on the next posedge
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    $display("txn op=%03b a=0x%08h b=0x%08h", op, a, b);
  endtask

  // Issue a single-cycle op with ready_i=1 and check the result one cycle later
  task automatic single(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    #1 check({tag, "_ready"}, 32'(ready_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_data"},  data_o, exp);
    check({tag, "_zero"},  32'(Zero_o), 32'(exp == 32'd0));
    @(negedge clk_i);
    check({tag, "_drop"}, 32'(valid_o), 32'd0);
  endtask

  int k;
  int busy_cnt;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    ALUCtrl_i = 3'b000; data1_i = '0; data2_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy",  32'(busy_o),  32'd0);
    check("rst_data",  data_o,       32'd0);
    check("rst_zero",  32'(Zero_o),  32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);

    // Single-cycle ops
    single("add_ovf", 3'b001, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    single("sub_zero", 3'b010, 32'd5, 32'd5, 32'd0);
    single("sra", 3'b111, 32'h8000_0000, 32'd4, 32'hF800_0000);
    single("sll31", 3'b000, 32'd1, 32'd31, 32'h8000_0000);
    single("sll_mask", 3'b000, 32'd1, 32'h0000_0021, 32'h0000_0002);
    single("and", 3'b011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    single("rsv", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

    // MUL 0xFFFFFFFF*3: 32 busy cycles, result lands on the 32nd edge after accept
    drive(3'b110, 32'hFFFF_FFFF, 32'd3);
    @(negedge clk_i);
    valid_i = 1'b0;
    busy_cnt = (busy_o && !ready_o && !valid_o) ? 1 : 0;
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_i);
      if (valid_o) begin
        k = i;
        break;
      end
      if (busy_o && !ready_o) busy_cnt++;
    end
    check("mul_latency", 32'(k), 32'd32);
    check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    check("mul_data", data_o, 32'hFFFF_FFFD);
    check("mul_busy_done", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("mul_drop", 32'(valid_o), 32'd0);

    // Signed operands: low half matches (-2)*(-3)
    drive(3'b110, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (32) @(negedge clk_i);
    check("muls_valid", 32'(valid_o), 32'd1);
    check("muls_data", data_o, 32'd6);
    @(negedge clk_i);

    // Stalled HOLD: result stable, new requests ignored
    ready_i = 1'b0;
    drive(3'b001, 32'd2, 32'd3);
    @(negedge clk_i);
    drive(3'b001, 32'd10, 32'd20);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_data",  data_o,       32'd5);
      check("hold_ready", 32'(ready_o), 32'd0);
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    drive(3'b010, 32'd10, 32'd3);
    #1 check("hold_release_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("b2b_valid", 32'(valid_o), 32'd1);
    check("b2b_data",  data_o,       32'd7);
    @(negedge clk_i);

    // Reset in the middle of a MUL
    drive(3'b110, 32'd7, 32'd9);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("mrst_valid", 32'(valid_o), 32'd0);
    check("mrst_busy",  32'(busy_o),  32'd0);
    check("mrst_ready", 32'(ready_o), 32'd1);
    check("mrst_zero",  32'(Zero_o),  32'd1);
    @(negedge clk_i);
    single("post_rst_add", 3'b001, 32'd1, 32'd1, 32'd2);

    // Flush a stalled result
    ready_i = 1'b0;
    drive(3'b001, 32'd4, 32'd4);
    @(negedge clk_i);
    check("fl_valid_pre", 32'(valid_o), 32'd1);
    check("fl_data_pre",  data_o,       32'd8);
    flush_i = 1'b1;
    ready_i = 1'b1;
    drive(3'b100, 32'd1, 32'd2);
    #1 check("fl_ready", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    check("fl_valid", 32'(valid_o), 32'd0);
    check("fl_ready_after", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    check("fl_no_accept", 32'(valid_o), 32'd0);

    // Flush an in-flight MUL
    drive(3'b110, 32'd5, 32'd5);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flm_busy", 32'(busy_o), 32'd0);
    check("flm_valid", 32'(valid_o), 32'd0);

    // Four back-to-back ORs, one result per cycle
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(3'b100, 32'h1 << i, 32'h100 << i);
      #1 check("or_ready", 32'(ready_o), 32'd1);
      @(negedge clk_i);
      check("or_valid", 32'(valid_o), 32'd1);
      check("or_data", data_o, (32'h1 << i) | (32'h100 << i));
    end
    valid_i = 1'b0;
    @(negedge clk_i);
    check("or_drop", 32'(valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
